// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address,
// and loads the fetched word into the IF/ID register. Honours stall, EX-stage
// redirect, and stops fetching after a HALT opcode.
// Optional macro FETCH_PERF_EN adds fetch_count / bubble_count perf counters.
module fetch_stage #(
  parameter int unsigned          ADDR_W      = 8,
  parameter int unsigned          INSTR_W     = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC    = '0,
  parameter logic [3:0]           HALT_OPCODE = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [ADDR_W-1:0]  ifid_pc_next,
`ifdef FETCH_PERF_EN
  output logic [15:0]        fetch_count,
  output logic [15:0]        bubble_count,
`endif
  output logic               halted
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n;
  logic               valid_n;
  logic [INSTR_W-1:0] instr_n;
  logic [ADDR_W-1:0]  ifid_pc_n, ifid_pc_next_n;
  logic               is_halt;
  logic               fetch_evt, bubble_evt;

  assign imem_addr = pc;
  assign halted    = (state == HALTED);
  assign is_halt   = (imem_rdata[INSTR_W-1 -: 4] == HALT_OPCODE);

  // Next-state logic with priority redirect > stall > normal advance.
  always_comb begin
    state_n        = state;
    pc_n           = pc;
    valid_n        = ifid_valid;
    instr_n        = ifid_instr;
    ifid_pc_n      = ifid_pc;
    ifid_pc_next_n = ifid_pc_next;
    fetch_evt      = 1'b0;
    bubble_evt     = 1'b0;
    if (redirect) begin
      pc_n       = redirect_pc;
      valid_n    = 1'b0;
      instr_n    = '0;
      state_n    = RUN;
      bubble_evt = 1'b1;
    end else if (!stall) begin
      if (state == RUN) begin
        instr_n        = imem_rdata;
        ifid_pc_n      = pc;
        ifid_pc_next_n = pc + ADDR_W'(1);
        valid_n        = 1'b1;
        fetch_evt      = 1'b1;
        if (is_halt) state_n = HALTED;
        else         pc_n    = pc + ADDR_W'(1);
      end else begin
        valid_n    = 1'b0;
        instr_n    = '0;
        bubble_evt = 1'b1;
      end
    end
  end

  // State, PC and IF/ID register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      pc           <= RESET_PC;
      ifid_valid   <= 1'b0;
      ifid_instr   <= '0;
      ifid_pc      <= '0;
      ifid_pc_next <= '0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      ifid_valid   <= valid_n;
      ifid_instr   <= instr_n;
      ifid_pc      <= ifid_pc_n;
      ifid_pc_next <= ifid_pc_next_n;
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating counters of loaded instructions and non-reset bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (fetch_evt && fetch_count != '1)   fetch_count  <= fetch_count + 16'd1;
      if (bubble_evt && bubble_count != '1) bubble_count <= bubble_count + 16'd1;
    end
  end
`else
  logic unused_evt;
  assign unused_evt = fetch_evt ^ bubble_evt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural model, per-cycle compare,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [7:0]  redirect_pc;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [7:0]  ifid_pc, ifid_pc_next;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count, bubble_count;
`endif

  logic [15:0] imem [256];
  assign imem_rdata = imem[imem_addr];

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00), .HALT_OPCODE(4'hF)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_pc_next(ifid_pc_next),
`ifdef FETCH_PERF_EN
    .fetch_count(fetch_count), .bubble_count(bubble_count),
`endif
    .halted(halted)
  );

  // Behavioural model of the fetch stage.
  logic [7:0]  m_pc, m_ip, m_ipn;
  logic        m_v, m_h;
  logic [15:0] m_i;
  int unsigned m_fc, m_bc;

  always @(posedge clk) begin
    if (rst) begin
      m_pc <= 8'h00; m_v <= 1'b0; m_i <= '0; m_ip <= '0; m_ipn <= '0;
      m_h <= 1'b0; m_fc <= 0; m_bc <= 0;
    end else if (redirect) begin
      m_pc <= redirect_pc; m_v <= 1'b0; m_i <= '0; m_h <= 1'b0;
      m_bc <= (m_bc < 65535) ? m_bc + 1 : m_bc;
    end else if (!stall) begin
      if (!m_h) begin
        m_i <= imem[m_pc]; m_ip <= m_pc; m_ipn <= m_pc + 8'd1; m_v <= 1'b1;
        m_fc <= (m_fc < 65535) ? m_fc + 1 : m_fc;
        if (imem[m_pc][15:12] == 4'hF) m_h <= 1'b1;
        else m_pc <= m_pc + 8'd1;
      end else begin
        m_v <= 1'b0; m_i <= '0;
        m_bc <= (m_bc < 65535) ? m_bc + 1 : m_bc;
      end
    end
  end

  int unsigned n_pass = 0, n_total = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic cmp_all();
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("ifid_valid", 32'(ifid_valid), 32'(m_v));
    chk("ifid_instr", 32'(ifid_instr), 32'(m_i));
    chk("ifid_pc", 32'(ifid_pc), 32'(m_ip));
    chk("ifid_pc_next", 32'(ifid_pc_next), 32'(m_ipn));
    chk("halted", 32'(halted), 32'(m_h));
`ifdef FETCH_PERF_EN
    chk("fetch_count", 32'(fetch_count), m_fc);
    chk("bubble_count", 32'(bubble_count), m_bc);
`endif
  endtask

  // Apply one cycle of inputs, then compare at the falling edge.
  task automatic step(input logic r, input logic s, input logic rd, input logic [7:0] rpc);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    @(negedge clk);
    if (check_en) cmp_all();
  endtask

  task automatic free(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 256; i++) imem[i] = 16'($urandom_range(0, 16'hEFFF));
    imem[0] = 16'h1001; imem[1] = 16'h2002; imem[2] = 16'h3003;
    imem[5] = 16'hF000; imem[8'h40] = 16'h4444; imem[8'h10] = 16'h1010;
    imem[8'hFF] = 16'h0FFF;

    // Reset, then three free edges.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check_en = 1'b1;
    cmp_all();
    chk("rst_valid", 32'(ifid_valid), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    free(1); chk("seq0_instr", 32'(ifid_instr), 32'h1001); chk("seq0_valid", 32'(ifid_valid), 32'd1);
    free(1); chk("seq1_instr", 32'(ifid_instr), 32'h2002);
    free(1); chk("seq2_instr", 32'(ifid_instr), 32'h3003); chk("seq2_pc", 32'(ifid_pc), 32'd2);
    chk("seq2_addr", 32'(imem_addr), 32'd3);

    // Stall at pc=2.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    free(2);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("stall_addr", 32'(imem_addr), 32'd2); chk("stall_instr", 32'(ifid_instr), 32'h2002);
    chk("stall_pc", 32'(ifid_pc), 32'd1);
    free(1); chk("unstall_instr", 32'(ifid_instr), 32'h3003); chk("unstall_pc", 32'(ifid_pc), 32'd2);

    // Redirect wins over simultaneous stall.
    step(1'b0, 1'b1, 1'b1, 8'h40);
    chk("redir_addr", 32'(imem_addr), 32'h40); chk("redir_valid", 32'(ifid_valid), 32'd0);
    chk("redir_instr", 32'(ifid_instr), 32'd0);
    free(1); chk("redir_fetch", 32'(ifid_instr), 32'h4444); chk("redir_fpc", 32'(ifid_pc), 32'h40);

    // HALT at address 5, bubbles, then redirect resumes.
    step(1'b0, 1'b0, 1'b1, 8'h05);
    free(1); chk("halt_instr", 32'(ifid_instr), 32'hF000); chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_addr", 32'(imem_addr), 32'd5);
    free(3); chk("halt_bubble", 32'(ifid_valid), 32'd0); chk("halt_hold", 32'(imem_addr), 32'd5);
    step(1'b0, 1'b0, 1'b1, 8'h10);
    chk("resume_halted", 32'(halted), 32'd0); chk("resume_addr", 32'(imem_addr), 32'h10);
    free(1); chk("resume_instr", 32'(ifid_instr), 32'h1010);

    // PC wrap.
    step(1'b0, 1'b0, 1'b1, 8'hFF);
    free(1); chk("wrap_pc", 32'(ifid_pc), 32'hFF); chk("wrap_next", 32'(ifid_pc_next), 32'h00);
    chk("wrap_addr", 32'(imem_addr), 32'h00);

    // Reset while halted and stalled.
    step(1'b0, 1'b0, 1'b1, 8'h05);
    free(1);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("rsth_addr", 32'(imem_addr), 32'd0); chk("rsth_halted", 32'(halted), 32'd0);
    chk("rsth_valid", 32'(ifid_valid), 32'd0);
`ifdef FETCH_PERF_EN
    chk("rsth_fc", 32'(fetch_count), 32'd0); chk("rsth_bc", 32'(bubble_count), 32'd0);
`endif

    // Randomized phase with real HALT opcodes in memory.
    for (int i = 0; i < 256; i++) imem[i] = 16'($urandom);
    for (int unsigned c = 0; c < 3000; c++)
      step($urandom_range(0, 99) < 2, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, 8'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined multicycle processor. It owns the program counter, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register consumed by the decode stage. It honours stall from the hazard unit and redirect from the execute-stage branch resolver, and it stops fetching on a HALT opcode.

Parameters:
ADDR_W, 8, PC / instruction-memory address width (word addressed)
INSTR_W, 16, instruction width
RESET_PC, 0, PC value loaded on reset
HALT_OPCODE, 4'hF, opcode (instr[INSTR_W-1:INSTR_W-4]) that halts fetch

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  hold PC and IF/ID (from hazard unit)
redirect  in  1  taken branch/jump resolved in EX; flush and reload PC
redirect_pc  in  ADDR_W  target address for redirect
imem_addr  out  ADDR_W  instruction-memory read address (combinational = pc)
imem_rdata  in  INSTR_W  instruction word, combinational read of imem_addr
ifid_valid  out  1  IF/ID holds a real instruction
ifid_instr  out  INSTR_W  fetched instruction (0 = NOP when invalid)
ifid_pc  out  ADDR_W  address of ifid_instr
ifid_pc_next  out  ADDR_W  ifid_pc+1 mod 2^ADDR_W (link value)
halted  out  1  fetch stopped on HALT

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- State: pc register, IF/ID register, 2-state FSM {RUN, HALTED}.
- Reset (rst=1 at a rising edge): pc=RESET_PC, FSM=RUN, ifid_valid=0, ifid_instr=0, ifid_pc=0, ifid_pc_next=0, halted=0. rst overrides all other inputs, including mid-stall or mid-halt.
- Per-cycle priority: rst > redirect > stall > normal advance.
- redirect=1 in either state: pc<=redirect_pc; ifid_valid<=0; ifid_instr<=0; ifid_pc and ifid_pc_next hold; FSM<=RUN; halted<=0. Redirect wins over a simultaneous stall.
- stall=1, redirect=0: pc, IF/ID, and FSM all hold. imem_addr is unchanged.
- RUN, no stall or redirect: ifid_instr<=imem_rdata; ifid_pc<=pc; ifid_pc_next<=pc+1; ifid_valid<=1.
  - If opcode != HALT_OPCODE: pc<=pc+1, wrapping from 2^ADDR_W-1 to 0.
  - If opcode == HALT_OPCODE: the HALT instruction is still passed to IF/ID; pc holds; FSM<=HALTED; halted<=1 in the same edge.
- HALTED, no stall or redirect: pc holds; ifid_valid<=0 and ifid_instr<=0, so a bubble drains downstream; halted stays 1.
- HALTED with stall: everything holds.
- Latency: the word at address A appears on ifid_* one edge after pc=A in RUN without stall. With no stalls or redirects, throughput is one instruction per cycle.
- Redirect to the current pc is legal: the IF/ID slot is flushed and that address is refetched next cycle.
- All arithmetic is unsigned modulo 2^ADDR_W; no overflow flag.

Optional Feature:
Macro FETCH_PERF_EN. When defined, two extra output ports are present:
- fetch_count [15:0]: counts edges where ifid_valid is loaded with 1.
- bubble_count [15:0]: counts edges where ifid_valid is loaded with 0 for a non-reset reason (redirect, or HALTED bubble). Stall edges are not counted.
Both counters reset to 0 on rst and saturate at 16'hFFFF. When the macro is undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=0 and imem holding 0x1001,0x2002,0x3003 at addresses 0..2, then 3 free edges -> ifid_instr sequence 0x1001,0x2002,0x3003; ifid_pc 0,1,2; ifid_valid=1 from the first edge; imem_addr=3.
- stall=1 for 2 edges at pc=2 -> pc, ifid_instr, and ifid_pc frozen; after release, 0x3003 is loaded with ifid_pc=2.
- redirect=1 with redirect_pc=0x40 and stall=1 in the same cycle -> next edge pc=0x40, ifid_valid=0, ifid_instr=0; following edge loads imem[0x40] with ifid_pc=0x40.
- Fetch 0xF000 at address 5 -> ifid_instr=0xF000, halted=1, pc=5; the next 3 edges give ifid_valid=0 with pc held at 5; then redirect to 0x10 -> halted=0 and fetch resumes at 0x10.
- Set pc=0xFF via redirect, then one free edge -> ifid_pc=0xFF, ifid_pc_next=0x00, pc=0x00.
- Assert rst while HALTED and mid-stall -> next edge pc=RESET_PC, halted=0, ifid_valid=0; with FETCH_PERF_EN, both counters read 0.
